int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 26 ++
 rtl/int_ctrl.sv | 100 ++++++++++
 tb/tb_int_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// Handshake bundle between the interrupt controller and the control unit.
// The control unit owns the master side; int_ctrl is the slave.
interface int_ctrl_if;
  logic [3:0] irq;
  logic       IF_set;
  logic       IF_clear;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       int_ret;
  logic       int_req;
  logic [2:0] int_num;
  logic       IF_out;
  logic [3:0] pending;
  logic [3:0] in_service;

  modport master (
    output irq, IF_set, IF_clear, mask_we, mask_in, int_ack, int_ret,
    input  int_req, int_num, IF_out, pending, in_service
  );

  modport slave (
    input  irq, IF_set, IF_clear, mask_we, mask_in, int_ack, int_ret,
    output int_req, int_num, IF_out, pending, in_service
  );
endinterface

// File: rtl/int_ctrl.sv
// 4-source priority interrupt controller with nesting, mask and global enable.
// int_req rises 1 cycle after a qualifying pending bit; the offer holds until int_ack.
module int_ctrl (
  input  logic       clk,
  input  logic       reset,
  int_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] sync1, sync2, sync_prev, rise;
  logic [3:0] pending, in_service, mask;
  logic       if_flag;
  logic [3:0] elig, elig_low, isr_low;
  logic [1:0] cand_idx;
  logic       prio_ok, qualify, ack;
  logic [3:0] ack_set, ret_clr;

  assign rise     = sync2 & ~sync_prev;
  assign elig     = pending & ~mask;
  assign elig_low = elig & (~elig + 4'd1);
  assign isr_low  = in_service & (~in_service + 4'd1);
  // One-hot compare: a lower index means a numerically smaller one-hot value.
  assign prio_ok  = (in_service == 4'd0) || (elig_low < isr_low);
  assign qualify  = if_flag && (elig != 4'd0) && prio_ok;
  assign ack_set  = ack ? (4'b0001 << idx) : 4'b0000;
  assign ret_clr  = bus.int_ret ? isr_low : 4'b0000;

  always_comb begin
    cand_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) cand_idx = i[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    ack         = 1'b0;
    bus.int_req = 1'b0;
    bus.int_num = 3'd0;
    case (state)
      IDLE: begin
        if (qualify) begin
          state_nxt = REQ;
          idx_nxt   = cand_idx;
        end
      end
      REQ: begin
        bus.int_req = 1'b1;
        bus.int_num = {1'b0, idx} + 3'd1;
        if (bus.int_ack) state_nxt = ACK;
      end
      ACK: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 4'd0;
      sync2      <= 4'd0;
      sync_prev  <= 4'd0;
      pending    <= 4'd0;
      in_service <= 4'd0;
      mask       <= 4'b1111;
      if_flag    <= 1'b0;
    end else begin
      sync1      <= bus.irq;
      sync2      <= sync1;
      sync_prev  <= sync2;
      // A fresh edge on the bit being acknowledged keeps it pending.
      pending    <= (pending & ~ack_set) | rise;
      in_service <= (in_service & ~ret_clr) | ack_set;
      if (bus.mask_we) mask <= bus.mask_in;
      if (bus.IF_clear)     if_flag <= 1'b0;
      else if (bus.int_ret) if_flag <= 1'b1;
      else if (ack)         if_flag <= 1'b0;
      else if (bus.IF_set)  if_flag <= 1'b1;
    end
  end

  assign bus.IF_out     = if_flag;
  assign bus.pending    = pending;
  assign bus.in_service = in_service;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: grant flow, priority, nesting, masking, reset abort.
module tb_int_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    bus.irq = v;
    tick(1);
    bus.irq = 4'd0;
  endtask

  task automatic do_ack();
    bus.int_ack = 1'b1;
    tick(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic do_ret();
    bus.int_ret = 1'b1;
    tick(1);
    bus.int_ret = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.irq = 4'd0; bus.IF_set = 1'b0; bus.IF_clear = 1'b0;
    bus.mask_we = 1'b0; bus.mask_in = 4'd0; bus.int_ack = 1'b0; bus.int_ret = 1'b0;
    tick(2);
    chk("rst_int_req", {7'd0, bus.int_req}, 8'h00);
    chk("rst_int_num", {5'd0, bus.int_num}, 8'h00);
    chk("rst_if", {7'd0, bus.IF_out}, 8'h00);
    chk("rst_pending", {4'd0, bus.pending}, 8'h00);
    chk("rst_in_service", {4'd0, bus.in_service}, 8'h00);
    chk("rst_mask", {4'd0, dut.mask}, 8'h0F);
    #2 reset = 1'b1;

    // int_ack outside REQ does nothing
    tick(1);
    do_ack();
    tick(1);
    chk("stray_ack", {3'd0, bus.int_req, bus.in_service}, 8'h00);

    // Single grant on irq[2]
    bus.mask_we = 1'b1; bus.mask_in = 4'd0; bus.IF_set = 1'b1;
    tick(1);
    bus.mask_we = 1'b0; bus.IF_set = 1'b0;
    chk("if_set", {7'd0, bus.IF_out}, 8'h01);
    pulse_irq(4'b0100);
    tick(2);
    chk("g1_pending", {4'd0, bus.pending}, 8'h04);
    chk("g1_noreq_yet", {7'd0, bus.int_req}, 8'h00);
    tick(1);
    chk("g1_req", {4'd0, bus.int_req, bus.int_num}, 8'h0B);
    do_ack();
    chk("g1_ack_state", {4'd0, bus.int_req, bus.int_num}, 8'h00);
    tick(1);
    chk("g1_in_service", {4'd0, bus.in_service}, 8'h04);
    chk("g1_if", {7'd0, bus.IF_out}, 8'h00);
    chk("g1_pending_clr", {4'd0, bus.pending}, 8'h00);

    // Nesting: irq[3] blocked by in_service[2], irq[0] preempts
    bus.IF_set = 1'b1;
    tick(1);
    bus.IF_set = 1'b0;
    pulse_irq(4'b1000);
    tick(4);
    chk("nest_pend3", {4'd0, bus.pending}, 8'h08);
    chk("nest_blocked", {7'd0, bus.int_req}, 8'h00);
    pulse_irq(4'b0001);
    tick(3);
    chk("nest_req0", {4'd0, bus.int_req, bus.int_num}, 8'h09);
    do_ack();
    tick(1);
    chk("nest_isr", {bus.pending, bus.in_service}, 8'h85);
    do_ret();
    chk("nest_ret1", {3'd0, bus.IF_out, bus.in_service}, 8'h14);
    chk("nest_still_blk", {7'd0, bus.int_req}, 8'h00);
    do_ret();
    chk("nest_ret2", {3'd0, bus.IF_out, bus.in_service}, 8'h10);
    tick(1);
    chk("nest_req3", {4'd0, bus.int_req, bus.int_num}, 8'h0C);
    // ACK cycle coincides with int_ret: IF ends set, in_service gets bit 3
    do_ack();
    do_ret();
    chk("ack_ret_isr", {3'd0, bus.IF_out, bus.in_service}, 8'h18);
    chk("ack_ret_pend", {4'd0, bus.pending}, 8'h00);
    do_ret();
    chk("ret_clean", {3'd0, bus.IF_out, bus.in_service}, 8'h10);

    // Simultaneous irq[1] and irq[3]
    pulse_irq(4'b1010);
    tick(2);
    chk("pair_pending", {4'd0, bus.pending}, 8'h0A);
    tick(1);
    chk("pair_first", {4'd0, bus.int_req, bus.int_num}, 8'h0A);
    do_ack();
    tick(1);
    chk("pair_isr1", {bus.pending, bus.in_service}, 8'h82);
    do_ret();
    chk("pair_ret", {2'd0, bus.int_req, bus.IF_out, bus.in_service}, 8'h10);
    tick(1);
    chk("pair_second", {4'd0, bus.int_req, bus.int_num}, 8'h0C);
    do_ack();
    tick(1);
    chk("pair_isr3", {bus.pending, bus.in_service}, 8'h08);
    do_ret();

    // Mask blocks irq[1] until rewritten
    bus.mask_we = 1'b1; bus.mask_in = 4'b0010;
    tick(1);
    bus.mask_we = 1'b0;
    pulse_irq(4'b0010);
    tick(4);
    chk("mask_pending", {4'd0, bus.pending}, 8'h02);
    chk("mask_blocked", {7'd0, bus.int_req}, 8'h00);
    bus.mask_we = 1'b1; bus.mask_in = 4'b0000;
    tick(1);
    bus.mask_we = 1'b0;
    chk("mask_next_cyc", {7'd0, bus.int_req}, 8'h00);
    tick(1);
    chk("unmask_req", {4'd0, bus.int_req, bus.int_num}, 8'h0A);
    // Offer holds even when the source gets masked and IF is cleared
    bus.mask_we = 1'b1; bus.mask_in = 4'b1111; bus.IF_clear = 1'b1;
    tick(1);
    bus.mask_we = 1'b0; bus.IF_clear = 1'b0;
    tick(1);
    chk("req_held", {4'd0, bus.int_req, bus.int_num}, 8'h0A);
    do_ack();
    tick(1);
    chk("mask_isr", {4'd0, bus.in_service}, 8'h02);

    // IF_set and IF_clear together: clear wins
    bus.IF_set = 1'b1; bus.IF_clear = 1'b1;
    tick(1);
    bus.IF_set = 1'b0; bus.IF_clear = 1'b0;
    chk("if_clear_wins", {7'd0, bus.IF_out}, 8'h00);

    // Reset while in REQ
    bus.mask_we = 1'b1; bus.mask_in = 4'd0; bus.IF_set = 1'b1;
    tick(1);
    bus.mask_we = 1'b0; bus.IF_set = 1'b0;
    pulse_irq(4'b0001);
    tick(3);
    chk("pre_rst_req", {4'd0, bus.int_req, bus.int_num}, 8'h09);
    #2 reset = 1'b0;
    #1;
    chk("arst_req", {4'd0, bus.int_req, bus.int_num}, 8'h00);
    chk("arst_pend_isr", {bus.pending, bus.in_service}, 8'h00);
    chk("arst_mask_if", {3'd0, bus.IF_out, dut.mask}, 8'h0F);
    tick(1);
    reset = 1'b1;
    tick(4);
    chk("post_rst_idle", {3'd0, bus.int_req, bus.pending}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
